// File: rtl/vdg_pkg.sv
// Shared definitions for the VDG display address counter: default widths,
// graphics mode encodings and the mode-to-geometry lookup functions.
package vdg_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int OFFS_W_DEF = 13;
  localparam int BASE_W_DEF = 7;

  localparam logic [2:0] GMODE_0 = 3'd0;
  localparam logic [2:0] GMODE_1 = 3'd1;
  localparam logic [2:0] GMODE_2 = 3'd2;
  localparam logic [2:0] GMODE_3 = 3'd3;
  localparam logic [2:0] GMODE_4 = 3'd4;
  localparam logic [2:0] GMODE_5 = 3'd5;
  localparam logic [2:0] GMODE_6 = 3'd6;
  localparam logic [2:0] GMODE_7 = 3'd7;

  // Number of scan lines each memory row is displayed for.
  function automatic logic [3:0] mode_divisor(input logic alpha, input logic [2:0] gmode);
    logic [3:0] div;
    if (alpha) begin
      div = 4'd12;
    end else begin
      case (gmode)
        GMODE_0, GMODE_1, GMODE_2: div = 4'd3;
        GMODE_3, GMODE_4:          div = 4'd2;
        default:                   div = 4'd1;
      endcase
    end
    return div;
  endfunction

  // Bytes fetched per memory row.
  function automatic logic [5:0] mode_width(input logic alpha, input logic [2:0] gmode);
    logic [5:0] w;
    if (alpha) begin
      w = 6'd32;
    end else begin
      case (gmode)
        GMODE_0, GMODE_1, GMODE_3, GMODE_5: w = 6'd16;
        default:                            w = 6'd32;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/strobe_edge.sv
// Registered previous-sample edge detector. History resets high so strobes
// that idle high produce no edge when reset is released.
module strobe_edge (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_reg;

  // Capture last cycle's strobe level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prev_reg <= 1'b1;
    else         prev_reg <= d;
  end

  assign rise = d & ~prev_reg;
  assign fall = ~d & prev_reg;

endmodule

// File: rtl/vdg_address_counter.sv
// Display memory address generator. Counts bytes within a row, replays rows
// according to the latched mode, and forms addr = base*512 + offset.
module vdg_address_counter
  import vdg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OFFS_W = OFFS_W_DEF,
  parameter int BASE_W = BASE_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              da0,
  input  logic              hsn,
  input  logic              fsn,
  input  logic [2:0]        gmode,
  input  logic              alpha,
  input  logic [BASE_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              fetch
);

  // Strobe bundle: index 0 = da0, 1 = hsn, 2 = fsn.
  logic [2:0] strobe_in;
  logic [2:0] strobe_rise;
  logic [2:0] strobe_fall;

  assign strobe_in = {fsn, hsn, da0};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      strobe_edge u_edge (
        .clk    (clk),
        .resetn (resetn),
        .d      (strobe_in[gi]),
        .rise   (strobe_rise[gi]),
        .fall   (strobe_fall[gi])
      );
    end
  endgenerate

  logic fsn_ev, hsn_ev, da0_ev;
  assign fsn_ev = strobe_fall[2];
  assign hsn_ev = strobe_fall[1] & ~fsn_ev;
  assign da0_ev = strobe_rise[0] & ~strobe_fall[1] & ~fsn_ev;

  logic [OFFS_W-1:0] offset_reg, offset_next;
  logic [OFFS_W-1:0] line_start_reg, line_start_next;
  logic [3:0]        rep_cnt_reg, rep_cnt_next;
  logic [5:0]        col_cnt_reg, col_cnt_next;
  logic              alpha_lat_reg, alpha_lat_next;
  logic [2:0]        gmode_lat_reg, gmode_lat_next;
  logic [BASE_W-1:0] base_lat_reg, base_lat_next;
  logic              inc_reg, inc_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              fetch_reg;

  logic [3:0]        div;
  logic [5:0]        width;
  logic [OFFS_W-1:0] next_line;

  assign div       = mode_divisor(alpha_lat_reg, gmode_lat_reg);
  assign width     = mode_width(alpha_lat_reg, gmode_lat_reg);
  assign next_line = line_start_reg + OFFS_W'(width);

  // Counter next-state: frame beats line beats byte.
  always_comb begin
    offset_next     = offset_reg;
    line_start_next = line_start_reg;
    rep_cnt_next    = rep_cnt_reg;
    col_cnt_next    = col_cnt_reg;
    alpha_lat_next  = alpha_lat_reg;
    gmode_lat_next  = gmode_lat_reg;
    base_lat_next   = base_lat_reg;
    inc_next        = 1'b0;
    if (fsn_ev) begin
      offset_next     = '0;
      line_start_next = '0;
      rep_cnt_next    = '0;
      col_cnt_next    = '0;
      alpha_lat_next  = alpha;
      gmode_lat_next  = gmode;
      base_lat_next   = base;
    end else if (hsn_ev) begin
      col_cnt_next = '0;
      if (rep_cnt_reg == div - 4'd1) begin
        rep_cnt_next    = '0;
        line_start_next = next_line;
        offset_next     = next_line;
      end else begin
        rep_cnt_next = rep_cnt_reg + 4'd1;
        offset_next  = line_start_reg;
      end
    end else if (da0_ev && (col_cnt_reg < width)) begin
      offset_next  = offset_reg + OFFS_W'(1);
      col_cnt_next = col_cnt_reg + 6'd1;
      inc_next     = 1'b1;
    end
  end

  // Output address is base*512 plus the frame offset, modulo 2^ADDR_W.
  assign addr_next = ADDR_W'({base_lat_reg, 9'b0}) + ADDR_W'(offset_reg);

  // Counter state plus a second stage that registers addr and fetch together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      offset_reg     <= '0;
      line_start_reg <= '0;
      rep_cnt_reg    <= '0;
      col_cnt_reg    <= '0;
      alpha_lat_reg  <= 1'b1;
      gmode_lat_reg  <= GMODE_0;
      base_lat_reg   <= '0;
      inc_reg        <= 1'b0;
      addr_reg       <= '0;
      fetch_reg      <= 1'b0;
    end else begin
      offset_reg     <= offset_next;
      line_start_reg <= line_start_next;
      rep_cnt_reg    <= rep_cnt_next;
      col_cnt_reg    <= col_cnt_next;
      alpha_lat_reg  <= alpha_lat_next;
      gmode_lat_reg  <= gmode_lat_next;
      base_lat_reg   <= base_lat_next;
      inc_reg        <= inc_next;
      addr_reg       <= addr_next;
      fetch_reg      <= inc_reg;
    end
  end

  assign addr  = addr_reg;
  assign fetch = fetch_reg;

endmodule

// File: tb/tb_vdg_address_counter.sv
// Directed bench for vdg_address_counter: strobes driven on the falling
// clock edge, outputs sampled on the falling edge.
module tb_vdg_address_counter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        da0 = 1'b0;
  logic        hsn = 1'b1;
  logic        fsn = 1'b1;
  logic [2:0]  gmode = 3'd0;
  logic        alpha = 1'b0;
  logic [6:0]  base = 7'd0;
  logic [15:0] addr;
  logic        fetch;

  int checks = 0;
  int errors = 0;
  int fetch_total = 0;

  always #5 clk = ~clk;

  vdg_address_counter dut (
    .clk    (clk),
    .resetn (resetn),
    .da0    (da0),
    .hsn    (hsn),
    .fsn    (fsn),
    .gmode  (gmode),
    .alpha  (alpha),
    .base   (base),
    .addr   (addr),
    .fetch  (fetch)
  );

  // Count fetch strobes, sampled away from the active edge.
  always @(negedge clk) begin
    if (fetch) fetch_total++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic da0_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) da0 = 1'b1;
      @(negedge clk) da0 = 1'b0;
    end
  endtask

  task automatic hsn_pulse;
    @(negedge clk) hsn = 1'b0;
    @(negedge clk) hsn = 1'b1;
    idle(3);
  endtask

  task automatic fsn_pulse;
    @(negedge clk) fsn = 1'b0;
    @(negedge clk) fsn = 1'b1;
    idle(3);
  endtask

  task automatic check_addr(input string name, input logic [15:0] exp);
    checks++;
    if (addr !== exp) begin
      errors++;
      $display("FAIL %s: addr=0x%04h expected 0x%04h", name, addr, exp);
    end else begin
      $display("check %s: addr=0x%04h", name, addr);
    end
  endtask

  task automatic check_fetches(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: fetch count=%0d expected %0d", name, got, exp);
    end else begin
      $display("check %s: fetch count=%0d", name, got);
    end
  endtask

  task automatic test_reset;
    int bad;
    int f0;
    bad = 0;
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (addr !== 16'h0000 || fetch !== 1'b0) bad++;
      da0 = ~da0;
      hsn = ~hsn;
      fsn = ~fsn;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_hold: %0d cycles with addr/fetch nonzero, expected 0", bad);
    end else begin
      $display("check reset_hold: addr=0 fetch=0 throughout");
    end
    @(negedge clk);
    da0 = 1'b0; hsn = 1'b1; fsn = 1'b1;
    @(negedge clk);
    f0 = fetch_total;
    resetn = 1'b1;
    idle(5);
    check_fetches("reset_release_fetch", fetch_total - f0, 0);
    check_addr("reset_release_addr", 16'h0000);
  endtask

  task automatic test_gmode7;
    int f0;
    gmode = 3'd7; alpha = 1'b0; base = 7'd0;
    fsn_pulse();
    f0 = fetch_total;
    da0_pulses(32); hsn_pulse();
    check_addr("g7_line1", 16'h0020);
    da0_pulses(32); hsn_pulse();
    check_addr("g7_line2", 16'h0040);
    check_fetches("g7_fetch", fetch_total - f0, 64);
  endtask

  task automatic test_gmode0;
    gmode = 3'd0; alpha = 1'b0; base = 7'h02;
    fsn_pulse();
    check_addr("g0_frame", 16'h0400);
    da0_pulses(16); hsn_pulse();
    check_addr("g0_hsn1", 16'h0400);
    da0_pulses(16); hsn_pulse();
    check_addr("g0_hsn2", 16'h0400);
    da0_pulses(16); hsn_pulse();
    check_addr("g0_hsn3", 16'h0410);
  endtask

  task automatic test_alpha;
    alpha = 1'b1; gmode = 3'd0; base = 7'd0;
    fsn_pulse();
    for (int l = 1; l <= 12; l++) begin
      da0_pulses(32); hsn_pulse();
      check_addr($sformatf("alpha_hsn%0d", l), (l == 12) ? 16'h0020 : 16'h0000);
    end
    alpha = 1'b0;
  endtask

  task automatic test_saturate;
    int f0;
    gmode = 3'd5; base = 7'd0;
    fsn_pulse();
    f0 = fetch_total;
    da0_pulses(20); idle(3);
    check_fetches("g5_sat_fetch", fetch_total - f0, 16);
    check_addr("g5_sat_addr", 16'h0010);
    hsn_pulse();
    check_addr("g5_sat_hsn", 16'h0010);
  endtask

  task automatic test_midframe_mode;
    gmode = 3'd7; base = 7'd0;
    fsn_pulse();
    gmode = 3'd3;
    da0_pulses(32); hsn_pulse();
    check_addr("midframe_mode", 16'h0020);
  endtask

  task automatic test_fsn_hsn_same;
    // Leave rep_cnt nonzero in a gmode-0 frame first.
    gmode = 3'd0; base = 7'd0;
    fsn_pulse();
    da0_pulses(5); hsn_pulse();
    da0_pulses(5); idle(3);
    check_addr("pre_coincide", 16'h0005);
    gmode = 3'd3;
    @(negedge clk) begin fsn = 1'b0; hsn = 1'b0; end
    @(negedge clk) begin fsn = 1'b1; hsn = 1'b1; end
    idle(3);
    check_addr("fsn_hsn_same", 16'h0000);
    da0_pulses(16); hsn_pulse();
    check_addr("fsn_hsn_rep0", 16'h0000);
    da0_pulses(16); hsn_pulse();
    check_addr("fsn_hsn_rep1", 16'h0010);
  endtask

  task automatic test_da0_hsn_same;
    int f0;
    gmode = 3'd7; base = 7'd0;
    fsn_pulse();
    da0_pulses(3); idle(3);
    check_addr("da0_hsn_pre", 16'h0003);
    f0 = fetch_total;
    @(negedge clk) begin da0 = 1'b1; hsn = 1'b0; end
    @(negedge clk) begin da0 = 1'b0; hsn = 1'b1; end
    idle(4);
    check_fetches("da0_hsn_fetch", fetch_total - f0, 0);
    check_addr("da0_hsn_addr", 16'h0020);
  endtask

  initial begin
    test_reset();
    test_gmode7();
    test_gmode0();
    test_alpha();
    test_saturate();
    test_midframe_mode();
    test_fsn_hsn_same();
    test_da0_hsn_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
